fetch_sequencer: RTL and testbench

//  Owns the program counter and sequences instruction fetch over a req/ack instruction-memory port.

---
 rtl/fetch_if.sv | 35 +++
 rtl/fetch_sequencer.sv | 146 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch-side bus bundle: the instruction-memory req/ack port plus the
// presented-instruction valid/ready port toward decode.
//
// Handshakes:
//   memory side : mem_req/mem_addr stay asserted and stable until a cycle
//                 with mem_ack=1. mem_ack is a single-cycle pulse carrying
//                 mem_rdata. A pulse while mem_req=0 has no effect.
//   decode side : instruction/cur_pc are meaningful while instr_valid=1 and
//                 stay stable until a rising clk edge with
//                 instr_valid & instr_ready, which is the transfer.
interface fetch_if #(
   parameter int WORD      = 64,
   parameter int INSTR_LEN = 32
);
   logic                 mem_req;
   logic [WORD-1:0]      mem_addr;
   logic                 mem_ack;
   logic [INSTR_LEN-1:0] mem_rdata;
   logic [INSTR_LEN-1:0] instruction;
   logic                 instr_valid;
   logic                 instr_ready;
   logic [WORD-1:0]      cur_pc;

   // Fetch sequencer side
   modport master (
      output mem_req, mem_addr, instruction, instr_valid, cur_pc,
      input  mem_ack, mem_rdata, instr_ready
   );

   // Memory / decode environment side
   modport slave (
      input  mem_req, mem_addr, instruction, instr_valid, cur_pc,
      output mem_ack, mem_rdata, instr_ready
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-counter owner and instruction-fetch sequencer. Issues one
// request at a time, holds the returned word until decode takes it,
// discards responses orphaned by a branch redirect, and parks in a sticky
// error state if memory fails to answer within TIMEOUT cycles.
module fetch_sequencer #(
   parameter int              WORD      = 64,
   parameter int              INSTR_LEN = 32,
   parameter logic [WORD-1:0] RESET_PC  = '0,
   parameter int              TIMEOUT   = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   input  logic            pc_src,
   input  logic [WORD-1:0] branch_target,
   fetch_if.master         bus,
   output logic            fetch_err,
   output logic [2:0]      fsm_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_DRAIN = 3'd2,
      S_HOLD  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t               state, state_nxt;
   logic [WORD-1:0]      pc, pc_nxt;
   logic [WORD-1:0]      addr_q;
   logic [INSTR_LEN-1:0] instr_q;
   logic [TW-1:0]        timer;
   logic [WORD-1:0]      target;
   logic                 timer_last;
   logic                 issue;      // start a fresh request at pc_nxt
   logic                 capture;    // latch mem_rdata as the held instruction
   logic                 timer_clr;
   logic                 timer_inc;

   // Redirect targets are word aligned; low two bits are dropped.
   assign target     = branch_target & ~WORD'(3);
   assign timer_last = (timer == TW'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state and datapath control decode
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      issue     = 1'b0;
      capture   = 1'b0;
      timer_clr = 1'b0;
      timer_inc = 1'b0;
      case (state)
         S_IDLE: begin
            if (pc_src) begin
               pc_nxt = target;
            end else if (run) begin
               state_nxt = S_REQ;
               issue     = 1'b1;
            end
         end
         S_REQ: begin
            if (bus.mem_ack) begin
               if (pc_src) begin
                  // Response belongs to the abandoned path: drop it.
                  pc_nxt    = target;
                  state_nxt = run ? S_REQ : S_IDLE;
                  issue     = run;
               end else begin
                  capture   = 1'b1;
                  state_nxt = S_HOLD;
               end
            end else if (pc_src) begin
               // Request already on the bus; wait out its ack before reissuing.
               pc_nxt    = target;
               state_nxt = S_DRAIN;
               timer_clr = 1'b1;
            end else if (timer_last) begin
               state_nxt = S_ERR;
            end else begin
               timer_inc = 1'b1;
            end
         end
         S_DRAIN: begin
            if (pc_src) pc_nxt = target;
            if (bus.mem_ack) begin
               state_nxt = run ? S_REQ : S_IDLE;
               issue     = run;
            end else if (timer_last) begin
               state_nxt = S_ERR;
            end else begin
               timer_inc = 1'b1;
            end
         end
         S_HOLD: begin
            if (bus.instr_ready || pc_src) begin
               pc_nxt    = pc_src ? target : pc + WORD'(4);
               state_nxt = run ? S_REQ : S_IDLE;
               issue     = run;
            end
         end
         S_ERR: begin
            state_nxt = S_ERR;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // PC, request address, held instruction and timeout timer
   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= RESET_PC;
         addr_q  <= RESET_PC;
         instr_q <= '0;
         timer   <= '0;
      end else begin
         pc <= pc_nxt;
         if (issue)   addr_q  <= pc_nxt;
         if (capture) instr_q <= bus.mem_rdata;
         if (issue || timer_clr) timer <= '0;
         else if (timer_inc)     timer <= timer + TW'(1);
      end
   end

   // Moore outputs
   always_comb begin
      bus.mem_req     = (state == S_REQ) || (state == S_DRAIN);
      bus.instr_valid = (state == S_HOLD);
      fetch_err       = (state == S_ERR);
      bus.mem_addr    = addr_q;
      bus.instruction = instr_q;
      bus.cur_pc      = pc;
      fsm_state       = state;
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by a randomized
// run, all checked cycle by cycle against a transaction-level model of the
// fetch rules (outstanding request / held word / sticky error).
module tb_fetch_sequencer;

   localparam int          WORD      = 64;
   localparam int          INSTR_LEN = 32;
   localparam int          TIMEOUT   = 16;
   localparam logic [63:0] RESET_PC  = 64'd0;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        pc_src;
   logic [63:0] branch_target;
   logic        fetch_err;
   logic [2:0]  fsm_state;

   always #5 clk = ~clk;

   fetch_if #(.WORD(WORD), .INSTR_LEN(INSTR_LEN)) bus ();

   fetch_sequencer #(
      .WORD(WORD), .INSTR_LEN(INSTR_LEN), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .run(run),
      .pc_src(pc_src),
      .branch_target(branch_target),
      .bus(bus),
      .fetch_err(fetch_err),
      .fsm_state(fsm_state)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [INSTR_LEN-1:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: what the fetch unit is doing, in transaction terms
   logic [63:0] m_pc;
   logic        m_out;       // a request is on the bus
   logic        m_live;      // that request still belongs to the current path
   logic        m_hold;      // a word is being presented
   logic        m_err;
   int          m_wait;      // cycles the request has waited since (re)start
   logic [63:0] m_req_addr;

   // Stimulus knobs
   logic        g_run = 1'b0, g_src = 1'b0, g_rdy = 1'b0;
   logic [63:0] g_tgt = '0;
   logic        ack_en = 1'b1, spur_en = 1'b0, last_ack = 1'b0;
   int          lat_lo = 1, lat_hi = 1, mem_cnt = -1;

   task automatic model_reset();
      m_pc = RESET_PC; m_out = 0; m_live = 0; m_hold = 0; m_err = 0; m_wait = 0;
      m_req_addr = '0;
      exp_q.delete();
      mem_cnt = -1;
   endtask

   task automatic check_outputs();
      check("cur_pc", bus.cur_pc, m_pc);
      check("mem_req", 64'(bus.mem_req), 64'(m_out));
      check("instr_valid", 64'(bus.instr_valid), 64'(m_hold));
      check("fetch_err", 64'(fetch_err), 64'(m_err));
      if (m_out) check("mem_addr", bus.mem_addr, m_req_addr);
      if (m_hold && exp_q.size() > 0) check("instruction", 64'(bus.instruction), 64'(exp_q[0]));
   endtask

   // ---------------- driver: one clock cycle ----------------
   task automatic cycle();
      logic        ack, src, rdy, run_i, consume, start;
      logic [31:0] rd;
      logic [63:0] tm, npc;
      rd  = $urandom;
      ack = 1'b0;
      if (!bus.mem_req) begin
         mem_cnt = -1;
         ack = spur_en && ($urandom_range(7, 0) == 0);
      end else if (ack_en) begin
         if (mem_cnt < 0) mem_cnt = $urandom_range(lat_hi, lat_lo);
         ack = (mem_cnt == 0);
         mem_cnt = ack ? -1 : mem_cnt - 1;
      end
      src = g_src; rdy = g_rdy; run_i = g_run;
      run = run_i; pc_src = src; branch_target = g_tgt;
      bus.instr_ready = rdy; bus.mem_ack = ack; bus.mem_rdata = rd;
      @(posedge clk);
      #1;
      last_ack = ack;
      g_src = 1'b0;
      if (!m_err) begin
         tm      = g_tgt & ~64'd3;
         consume = m_hold && rdy;
         npc     = src ? tm : (consume ? m_pc + 64'd4 : m_pc);
         start   = 1'b0;
         if (m_out) begin
            if (ack) begin
               m_out = 1'b0;
               if (m_live && !src) begin
                  m_hold = 1'b1;
                  exp_q.push_back(rd);
               end else begin
                  start = run_i;
               end
            end else if (src && m_live) begin
               m_live = 1'b0;
               m_wait = 0;
            end else if (m_wait == TIMEOUT - 1) begin
               m_err = 1'b1;
               m_out = 1'b0;
            end else begin
               m_wait++;
            end
         end else if (m_hold) begin
            if (consume || src) begin
               m_hold = 1'b0;
               if (exp_q.size() > 0) exp_q.delete(0);
               start = run_i;
            end
         end else begin
            start = run_i && !src;
         end
         if (start) begin
            m_out = 1'b1; m_live = 1'b1; m_wait = 0; m_req_addr = npc;
         end
         m_pc = npc;
      end
      check_outputs();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run = 1'b0; pc_src = 1'b0; branch_target = '0;
      bus.instr_ready = 1'b0; bus.mem_rdata = $urandom;
      bus.mem_ack = 1'($urandom_range(1, 0));
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check("rst_cur_pc", bus.cur_pc, RESET_PC);
      check("rst_mem_req", 64'(bus.mem_req), 64'd0);
      check("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
      check("rst_instruction", 64'(bus.instruction), 64'd0);
      check("rst_fetch_err", 64'(fetch_err), 64'd0);
      reset = 1'b0;
   endtask

   task automatic wait_req(input int bound);
      int n = 0;
      while (!bus.mem_req && n < bound) begin cycle(); n++; end
      check("wait_req", 64'(bus.mem_req), 64'd1);
   endtask

   task automatic wait_valid(input int bound);
      int n = 0;
      while (!bus.instr_valid && n < bound) begin cycle(); n++; end
      check("wait_valid", 64'(bus.instr_valid), 64'd1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [63:0] s_pc;
      logic [31:0] s_ins;
      int          n;
      bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.instr_ready = 1'b0;
      do_reset();

      // Sequential fetch from reset, memory answering one cycle late
      g_run = 1; g_rdy = 1; lat_lo = 1; lat_hi = 1;
      wait_req(4);
      check("t1_addr0", bus.mem_addr, 64'd0);
      wait_valid(8);
      check("t1_pc0", bus.cur_pc, 64'd0);
      cycle();
      check("t1_addr4", bus.mem_addr, 64'd4);
      wait_valid(8);
      cycle();
      check("t1_addr8", bus.mem_addr, 64'd8);

      // Redirect while an instruction is held
      g_rdy = 0;
      wait_valid(8);
      g_src = 1; g_tgt = 64'd36;
      cycle();
      check("t2_dropped", 64'(bus.instr_valid), 64'd0);
      check("t2_pc36", bus.cur_pc, 64'd36);
      check("t2_addr36", bus.mem_addr, 64'd36);
      wait_valid(8);
      g_rdy = 1;
      cycle();
      check("t2_pc40", bus.cur_pc, 64'd40);

      // Redirect while a request is outstanding: old response must vanish
      g_rdy = 0; lat_lo = 3; lat_hi = 3;
      wait_req(4);
      g_src = 1; g_tgt = 64'd24;
      cycle();
      n = 0;
      while (!last_ack && n < 10) begin cycle(); n++; end
      check("t3_ack_seen", 64'(last_ack), 64'd1);
      check("t3_no_valid", 64'(bus.instr_valid), 64'd0);
      check("t3_req", 64'(bus.mem_req), 64'd1);
      check("t3_addr24", bus.mem_addr, 64'd24);

      // Target alignment and PC wrap-around
      g_run = 0; g_rdy = 1; lat_lo = 1; lat_hi = 1;
      repeat (12) cycle();
      check("t4_idle", 64'(bus.mem_req), 64'd0);
      g_src = 1; g_tgt = 64'h27; g_run = 1;
      cycle();
      check("t4_pc24", bus.cur_pc, 64'h24);
      check("t4_no_req", 64'(bus.mem_req), 64'd0);
      cycle();
      check("t4_addr24", bus.mem_addr, 64'h24);
      wait_valid(8);
      g_src = 1; g_tgt = 64'hFFFF_FFFF_FFFF_FFFF;
      cycle();
      check("t4_addr_top", bus.mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      wait_valid(8);
      check("t4_pc_top", bus.cur_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      cycle();
      check("t4_wrap_pc", bus.cur_pc, 64'd0);
      check("t4_wrap_addr", bus.mem_addr, 64'd0);

      // Back-pressure holds the word; run=0 then stops cleanly
      g_rdy = 0;
      wait_valid(8);
      s_pc = bus.cur_pc; s_ins = bus.instruction;
      repeat (5) begin
         cycle();
         check("t5_pc_stable", bus.cur_pc, s_pc);
         check("t5_ins_stable", 64'(bus.instruction), 64'(s_ins));
         check("t5_no_req", 64'(bus.mem_req), 64'd0);
      end
      g_run = 0; g_rdy = 1;
      cycle();
      check("t5_consumed", 64'(bus.instr_valid), 64'd0);
      repeat (3) begin
         cycle();
         check("t5_stopped", 64'(bus.mem_req), 64'd0);
      end

      // Memory that never answers
      ack_en = 0; g_run = 1;
      wait_req(4);
      n = 0;
      while (bus.mem_req && n < 40) begin n++; cycle(); end
      check("t6_req_cycles", 64'(n), 64'(TIMEOUT));
      check("t6_err", 64'(fetch_err), 64'd1);
      check("t6_req_off", 64'(bus.mem_req), 64'd0);
      g_src = 1; g_tgt = 64'h100;
      repeat (3) cycle();
      do_reset();
      ack_en = 1;

      // Randomized traffic
      lat_lo = 0; lat_hi = 3; spur_en = 1;
      for (int i = 0; i < 3000; i++) begin
         g_run = ($urandom_range(9, 0) != 0);
         g_rdy = 1'($urandom_range(1, 0));
         g_src = ($urandom_range(9, 0) == 0);
         g_tgt = ($urandom_range(3, 0) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0)))
                                             : {$urandom, $urandom};
         if ($urandom_range(299, 0) == 0) do_reset();
         else cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
